// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: state encoding and default word width.
// S2P_PARITY_EN adds one odd-parity bit to each receive frame.
package spi_pkg;

    localparam int SPI_DEFAULT_W = 8;

    typedef enum logic [1:0] {
        S2P_IDLE  = 2'd0,
        S2P_SHIFT = 2'd1,
        S2P_HOLD  = 2'd2
    } s2p_state_t;

    function automatic int s2p_frame_len(input int w);
`ifdef S2P_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/serial_to_parallel_sr_if.sv
// Receive-side bus of the SPI slave: serial line in, word handshake out.
interface serial_to_parallel_sr_if
    import spi_pkg::*;
#(
    parameter int W = SPI_DEFAULT_W
);
    logic         SS_n;
    logic         MOSI;
    logic         rx_ack;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         frame_err;
    logic         overrun;

    modport slave (
        input  SS_n, MOSI, rx_ack,
        output rx_data, rx_valid, frame_err, overrun
    );

    modport master (
        output SS_n, MOSI, rx_ack,
        input  rx_data, rx_valid, frame_err, overrun
    );
endinterface

// File: rtl/s2p_bit_counter.sv
// Loadable/clearable up-counter with a terminal-count flag.
module s2p_bit_counter #(
    parameter int            CW   = 3,
    parameter logic [CW-1:0] TERM = '1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    output logic          tc
);
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERM);
endmodule

// File: rtl/serial_to_parallel_sr.sv
// SPI slave receive shift register: MSB-first frames into W-bit words with
// valid/ack handshake. Define S2P_PARITY_EN for a trailing odd-parity bit.
module serial_to_parallel_sr
    import spi_pkg::*;
#(
    parameter int W = SPI_DEFAULT_W
) (
    input logic                     clk,
    input logic                     rst_n,
    serial_to_parallel_sr_if.slave  bus
);
    localparam int FRAME_LEN = s2p_frame_len(W);
    localparam int CW        = $clog2(FRAME_LEN);

    localparam logic [1:0] ST_IDLE  = 2'(S2P_IDLE);
    localparam logic [1:0] ST_SHIFT = 2'(S2P_SHIFT);
    localparam logic [1:0] ST_HOLD  = 2'(S2P_HOLD);

    logic [1:0]   state;
    logic [W-1:0] sr;
    logic [W-1:0] shifted;
    logic [W-1:0] word;
    logic         word_ok;
    logic         last_bit;
    logic         cnt_clr;
    logic         cnt_load;
    logic         cnt_inc;

    logic [W-1:0] rx_data_q;
    logic         rx_valid_q;
    logic         frame_err_q;
    logic         overrun_q;

    assign shifted = W'({sr, bus.MOSI});

    // With parity the data is already in sr when the parity bit arrives.
`ifdef S2P_PARITY_EN
    assign word    = sr;
    assign word_ok = ^{sr, bus.MOSI};
`else
    assign word    = shifted;
    assign word_ok = 1'b1;
`endif

    always_comb begin
        cnt_load = (state == ST_IDLE) && !bus.SS_n;
        cnt_clr  = (state == ST_SHIFT) && (bus.SS_n || last_bit);
        cnt_inc  = (state == ST_SHIFT) && !bus.SS_n && !last_bit;
    end

    s2p_bit_counter #(
        .CW   (CW),
        .TERM (CW'(FRAME_LEN - 1))
    ) u_bit_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (CW'(1)),
        .inc      (cnt_inc),
        .tc       (last_bit)
    );

    // A completion that stores a word overrides the ack-driven clear of rx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sr          <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (bus.rx_ack && rx_valid_q) begin
                rx_valid_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!bus.SS_n) begin
                        sr    <= shifted;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.SS_n) begin
                        frame_err_q <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (last_bit) begin
                        state <= ST_HOLD;
                        if (!word_ok) begin
                            frame_err_q <= 1'b1;
                        end else if (!rx_valid_q || bus.rx_ack) begin
                            rx_data_q  <= word;
                            rx_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        sr <= shifted;
                    end
                end
                ST_HOLD: begin
                    if (bus.SS_n) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_to_parallel_sr.sv
// Self-checking bench for serial_to_parallel_sr (honours S2P_PARITY_EN).
module tb_serial_to_parallel_sr;
    import spi_pkg::*;

    localparam int W = SPI_DEFAULT_W;
`ifdef S2P_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FLEN = W + (PAR ? 1 : 0);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_to_parallel_sr_if #(.W(W)) bus ();

    serial_to_parallel_sr #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: counts bits of the current frame and applies the handshake rules.
    logic [W-1:0] exp_data;
    logic         exp_valid;
    logic         exp_ferr;
    logic         exp_ovr;
    int           nbits;
    bit           done;
    logic [W-1:0] acc;
    logic         par_bit;

    task automatic modelReset();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        nbits     = 0;
        done      = 1'b0;
        acc       = '0;
        par_bit   = 1'b0;
    endtask

    task automatic modelStep(input logic ss, input logic mosi, input logic ack);
        bit complete;
        bit ok;
        complete = 1'b0;
        ok       = 1'b1;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (ss) begin
            if (nbits > 0 && !done) exp_ferr = 1'b1;
            nbits = 0;
            done  = 1'b0;
        end else if (!done) begin
            if (nbits < W) acc = (acc << 1) | W'(mosi);
            else           par_bit = mosi;
            nbits++;
            if (nbits == FLEN) begin
                done     = 1'b1;
                complete = 1'b1;
            end
        end
        if (complete) begin
            if (PAR) ok = ((($countones(acc) + int'(par_bit)) % 2) == 1);
            if (!ok) begin
                exp_ferr = 1'b1;
                if (ack) exp_valid = 1'b0;
            end else if (!exp_valid || ack) begin
                exp_data  = acc;
                exp_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (ack) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic checkOutput();
        total++;
        assert (bus.rx_data === exp_data) else begin
            bad++;
            $error("[TB] FAIL rx_data got=%0h exp=%0h", bus.rx_data, exp_data);
        end
        total++;
        assert (bus.rx_valid === exp_valid) else begin
            bad++;
            $error("[TB] FAIL rx_valid got=%0b exp=%0b", bus.rx_valid, exp_valid);
        end
        total++;
        assert (bus.frame_err === exp_ferr) else begin
            bad++;
            $error("[TB] FAIL frame_err got=%0b exp=%0b", bus.frame_err, exp_ferr);
        end
        total++;
        assert (bus.overrun === exp_ovr) else begin
            bad++;
            $error("[TB] FAIL overrun got=%0b exp=%0b", bus.overrun, exp_ovr);
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ss, input logic mosi, input logic ack);
        bus.SS_n   = ss;
        bus.MOSI   = mosi;
        bus.rx_ack = ack;
        modelStep(ss, mosi, ack);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic sendRaw(input logic [W-1:0] data, input logic pbit, input logic ack_last);
        for (int i = 0; i < W; i++)
            applyStimulus(1'b0, data[W-1-i], (i == W-1 && !PAR) ? ack_last : 1'b0);
        if (PAR) applyStimulus(1'b0, pbit, ack_last);
    endtask

    task automatic sendBits(input logic [W-1:0] data, input logic ack_last);
        sendRaw(data, ~^data, ack_last);
    endtask

    task automatic gap();
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic ackCycle();
        applyStimulus(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        bus.SS_n   = 1'b1;
        bus.MOSI   = 1'b0;
        bus.rx_ack = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        checkVal("reset_valid", bus.rx_valid, 0);
        rst_n = 1'b1;

        $display("[TB] single frame 0xA5");
        sendBits(8'hA5, 1'b0);
        checkVal("a5_valid", bus.rx_valid, 1);
        checkVal("a5_data", bus.rx_data, 32'hA5);
        gap();
        ackCycle();
        checkVal("a5_ack_clears", bus.rx_valid, 0);

        $display("[TB] early abort after 5 bits");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, i[0], 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkVal("abort_ferr", bus.frame_err, 1);
        checkVal("abort_valid", bus.rx_valid, 0);
        checkVal("abort_data", bus.rx_data, 32'hA5);
        gap();
        checkVal("abort_ferr_pulse", bus.frame_err, 0);
        sendBits(8'h0F, 1'b0);
        checkVal("after_abort_data", bus.rx_data, 32'h0F);
        gap();
        ackCycle();

        $display("[TB] overrun");
        sendBits(8'h11, 1'b0);
        gap();
        sendBits(8'h22, 1'b0);
        checkVal("ovr_pulse", bus.overrun, 1);
        checkVal("ovr_data_kept", bus.rx_data, 32'h11);
        gap();
        checkVal("ovr_pulse_end", bus.overrun, 0);
        ackCycle();
        sendBits(8'h11, 1'b0);
        gap();
        sendBits(8'h22, 1'b1);
        checkVal("ack_on_done_data", bus.rx_data, 32'h22);
        checkVal("ack_on_done_valid", bus.rx_valid, 1);
        checkVal("ack_on_done_ovr", bus.overrun, 0);
        gap();
        ackCycle();

        $display("[TB] over-long frame");
        sendBits(8'hC3, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        gap();
        checkVal("long_data", bus.rx_data, 32'hC3);
        checkVal("long_ferr", bus.frame_err, 0);
        ackCycle();

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        checkVal("rst_mid_data", bus.rx_data, 0);
        bus.SS_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gap();
        sendBits(8'h3C, 1'b0);
        checkVal("post_rst_data", bus.rx_data, 32'h3C);
        gap();
        ackCycle();

        if (PAR) begin
            $display("[TB] parity");
            sendRaw(8'hA5, 1'b1, 1'b0);
            checkVal("par_ok_valid", bus.rx_valid, 1);
            gap();
            ackCycle();
            sendRaw(8'hA5, 1'b0, 1'b0);
            checkVal("par_bad_ferr", bus.frame_err, 1);
            checkVal("par_bad_valid", bus.rx_valid, 0);
            gap();
        end

        $display("[TB] random frames");
        for (int f = 0; f < 24; f++) begin
            sendBits(W'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 2)) gap();
            if ($urandom_range(0, 2) == 0) ackCycle();
        end

        $display("[TB] random cycles");
        for (int c = 0; c < 500; c++)
            applyStimulus(($urandom_range(0, 9) < 2), 1'($urandom), ($urandom_range(0, 9) < 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_to_parallel_sr.md
# serial_to_parallel_sr

Receive-side shift register of the SPI slave: samples MOSI one bit per `clk` while `SS_n` is low, assembles MSB-first frames into a `W`-bit word, and presents it on `rx_data` with a `rx_valid`/`rx_ack` handshake to the slave control logic. It is the counterpart of the slave's parallel-to-serial transmit register, which drives MISO MSB-first. It also reports aborted frames, overruns and (optionally) parity errors.

## Interface
- `W`, default 8: data word width, minimum 2.
- `clk` input, 1 bit: system/SPI clock; all sampling on rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `SS_n` input, 1 bit: slave select, active low; frames the transfer.
- `MOSI` input, 1 bit: serial data in, MSB first.
- `rx_ack` input, 1 bit: consumer has taken `rx_data`.
- `rx_data` output, W bits: last accepted word.
- `rx_valid` output, 1 bit: `rx_data` holds an unconsumed word.
- `frame_err` output, 1 bit: one-cycle pulse on aborted frame (or parity failure).
- `overrun` output, 1 bit: one-cycle pulse when a completed word is dropped.

## Operation
- States:
  - IDLE: `SS_n` high.
  - SHIFT: collecting bits.
  - HOLD: frame complete, `SS_n` still low.
- IDLE -> SHIFT on the first edge with `SS_n`=0. MOSI is sampled on that same edge as bit 0, and the bit counter becomes 1.
- SHIFT: each edge with `SS_n`=0 shifts MOSI in at the LSB (`{sr[W-2:0],MOSI}`) and increments the counter. On the edge sampling the last frame bit (counter = FRAME_LEN-1), the word completes and the state goes to HOLD.
- Frame length:
  - FRAME_LEN = W.
  - FRAME_LEN = W+1 with parity (see Configuration).
- HOLD: MOSI is ignored. Returns to IDLE on an edge with `SS_n`=1. A new frame needs `SS_n` to go high first.
- SHIFT with `SS_n`=1 (early deassert):
  - Frame aborted, state -> IDLE, counter cleared.
  - `frame_err` pulses one cycle.
  - `rx_data` and `rx_valid` unchanged.
- Completion with `rx_valid`=0, or with `rx_valid`=1 and `rx_ack`=1 on the same edge: `rx_data` <= word, `rx_valid` <= 1, no overrun.
- Completion with `rx_valid`=1 and `rx_ack`=0:
  - Word dropped, `rx_data` keeps the old value.
  - `overrun` pulses one cycle.
- `rx_ack` with `rx_valid`=1 and no completion: `rx_valid` <= 0 next edge. `rx_ack` with `rx_valid`=0 is ignored.
- Reset (any time, including mid-frame):
  - State IDLE, counter 0, shift register 0.
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0.

## Timing
- All outputs are registered and change only on `clk` rising edge or `rst_n` assertion.
- Latency: the last bit is sampled on edge N. `rx_data`/`rx_valid` are valid immediately after edge N, so a back-to-back W=8 frame starting at edge 0 shows `rx_valid`=1 after edge 7.
- `frame_err` and `overrun` are high for exactly one cycle, following the edge that detected the condition.
- `SS_n` and MOSI are synchronous to `clk`; no internal synchronizers.
- Minimum inter-frame gap: one cycle with `SS_n`=1.

## Configuration
- `S2P_PARITY_EN` defined:
  - Frame is W data bits followed by one odd-parity bit (the XOR of data and parity must be 1).
  - On mismatch the word is discarded, `rx_valid`/`rx_data` are unchanged, `frame_err` pulses, and `overrun` is not raised.
  - Counter width is `$clog2(W+1)`.
- Undefined: frame is exactly W bits, no parity logic, counter width is `$clog2(W)`.

## Structure
- Shared package `spi_pkg`:
  - State enum `s2p_state_t` (IDLE, SHIFT, HOLD).
  - Localparam for default word width, shared with the transmit register.
- One sub-module, `s2p_bit_counter`: loadable/clearable up-counter with a terminal-count flag at FRAME_LEN-1.
- The FSM, shift register and handshake live in the top.

## Test plan
- Reset: `rst_n`=0 mid-frame after 3 bits of 0xA5 -> all outputs 0; next full frame 0x3C -> `rx_data`=0x3C.
- Single frame: W=8, `SS_n` low 8 cycles, MOSI 0xA5 MSB-first, `rx_ack` held 0 -> `rx_valid`=1 after edge 7, `rx_data`=0xA5. `rx_ack` pulse -> `rx_valid`=0 next cycle.
- Early abort: `SS_n` rises after 5 bits -> `frame_err` one-cycle pulse, `rx_valid` stays 0, `rx_data` unchanged. Next full frame 0x0F is received correctly.
- Overrun: frame 0x11 with no ack, then frame 0x22 -> `overrun` pulses, `rx_data`=0x11. Repeat with `rx_ack`=1 on the completion edge -> `rx_data`=0x22, `rx_valid`=1, no overrun.
- Over-long frame: `SS_n` low 12 cycles with 0xC3 then 1111 -> `rx_data`=0xC3, extra bits ignored, no error.
- Parity (`S2P_PARITY_EN`): 0xA5 with parity bit 1 -> accepted. With parity bit 0 -> `frame_err` pulse, `rx_valid` stays 0.
